// File: rtl/score_overlay_px.sv
// Two-player decimal score overlay for a pixel stream: sequential binary->BCD capture,
// per-player blink after a score change, and a fixed 2-cycle colour pipeline.
module score_overlay_px #(
    parameter int          SCORE_W      = 16,
    parameter int          DIGITS       = 3,
    parameter int          SCALE_LOG2   = 2,
    parameter int          P0_X         = 16,
    parameter int          P1_X         = 560,
    parameter int          SCORE_Y      = 8,
    parameter logic [23:0] FG0          = 24'hFFFFFF,
    parameter logic [23:0] FG1          = 24'hFF4040,
    parameter int          BLINK_FRAMES = 32,
    parameter int          BLINK_BIT    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] your_score,
    input  logic [SCORE_W-1:0] their_score,
    input  logic [15:0]        game_state,
    input  logic [15:0]        pixel_x,
    input  logic [15:0]        pixel_y,
    input  logic               frame_start,
    input  logic [23:0]        bg_color,
    output logic [23:0]        color,
    output logic               in_overlay,
    output logic               busy
);
    localparam int              BW        = 4 * DIGITS;
    localparam int              CNT_W     = $clog2(SCORE_W + 1);
    localparam int              BLK_W     = $clog2(BLINK_FRAMES + 1);
    localparam logic [31:0]     SAT_LIM   = 32'(10 ** DIGITS);
    localparam logic [BW-1:0]   ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t             state;
    logic               cur_p;
    logic [SCORE_W-1:0] lat0, lat1, shreg;
    logic [BW-1:0]      work, adj, work_next, bcd0, bcd1;
    logic [CNT_W-1:0]   cnt;
    logic [BLK_W-1:0]   blink0, blink1;
    logic               sat;

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    always_comb begin
        adj = work;
        for (int i = 0; i < DIGITS; i++)
            if (work[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        work_next = {adj[BW-2:0], shreg[SCORE_W-1]};
    end

    assign sat = 32'(cur_p ? lat1 : lat0) >= SAT_LIM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cur_p  <= 1'b0;
            lat0   <= '0;
            lat1   <= '0;
            shreg  <= '0;
            work   <= '0;
            cnt    <= '0;
            bcd0   <= '0;
            bcd1   <= '0;
            blink0 <= '0;
            blink1 <= '0;
            busy   <= 1'b0;
        end else begin
            if (frame_start) begin
                if (blink0 != '0) blink0 <= blink0 - BLK_W'(1);
                if (blink1 != '0) blink1 <= blink1 - BLK_W'(1);
            end
            case (state)
                IDLE: begin
                    if (your_score != lat0) begin
                        lat0  <= your_score;
                        shreg <= your_score;
                        cur_p <= 1'b0;
                        work  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end else if (their_score != lat1) begin
                        lat1  <= their_score;
                        shreg <= their_score;
                        cur_p <= 1'b1;
                        work  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    work  <= work_next;
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SCORE_W - 1)) begin
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // Written after the frame_start decrement so a same-cycle load wins.
                    if (cur_p) begin
                        bcd1   <= sat ? ALL_NINES : work;
                        blink1 <= BLK_W'(BLINK_FRAMES);
                    end else begin
                        bcd0   <= sat ? ALL_NINES : work;
                        blink0 <= BLK_W'(BLINK_FRAMES);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: region decode.
    logic [15:0] dy, dx0, dx1, dx_sel;
    logic        yhit, hit0, hit1;

    assign dy     = pixel_y - 16'(SCORE_Y);
    assign yhit   = (pixel_y >= 16'(SCORE_Y)) && ((dy >> SCALE_LOG2) < 16'd5);
    assign dx0    = pixel_x - 16'(P0_X);
    assign dx1    = pixel_x - 16'(P1_X);
    assign hit0   = yhit && (pixel_x >= 16'(P0_X)) && ((dx0 >> (SCALE_LOG2 + 2)) < 16'(DIGITS))
                    && (2'(dx0 >> SCALE_LOG2) != 2'd3);
    assign hit1   = yhit && (pixel_x >= 16'(P1_X)) && ((dx1 >> (SCALE_LOG2 + 2)) < 16'(DIGITS))
                    && (2'(dx1 >> SCALE_LOG2) != 2'd3);
    assign dx_sel = hit1 ? dx1 : dx0;

    logic        s1_hit, s1_p, s1_en;
    logic [2:0]  s1_dig, s1_row;
    logic [1:0]  s1_col;
    logic [23:0] s1_bg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_hit <= 1'b0;
            s1_p   <= 1'b0;
            s1_en  <= 1'b0;
            s1_dig <= '0;
            s1_row <= '0;
            s1_col <= '0;
            s1_bg  <= '0;
        end else begin
            s1_hit <= hit0 || hit1;
            s1_p   <= hit1;
            s1_en  <= game_state[1:0] != 2'b00;
            s1_dig <= 3'(dx_sel >> (SCALE_LOG2 + 2));
            s1_row <= 3'(dy >> SCALE_LOG2);
            s1_col <= 2'(dx_sel >> SCALE_LOG2);
            s1_bg  <= bg_color;
        end
    end

    // 3x5 glyphs, bit 14 = top-left, rows top to bottom, columns left to right.
    function automatic logic [14:0] glyph(input logic [3:0] g);
        case (g)
            4'd0:    glyph = 15'b111_101_101_101_111;
            4'd1:    glyph = 15'b010_110_010_010_111;
            4'd2:    glyph = 15'b111_001_111_100_111;
            4'd3:    glyph = 15'b111_001_111_001_111;
            4'd4:    glyph = 15'b101_101_111_001_001;
            4'd5:    glyph = 15'b111_100_111_001_111;
            4'd6:    glyph = 15'b111_100_111_101_111;
            4'd7:    glyph = 15'b111_001_001_001_001;
            4'd8:    glyph = 15'b111_101_111_101_111;
            4'd9:    glyph = 15'b111_101_111_001_111;
            default: glyph = 15'b0;
        endcase
    endfunction

    // Stage 2: digit select with leading-zero blanking, ROM lookup, colour mux.
    logic [BW-1:0] bcd_sel;
    logic [3:0]    digit, bit_idx;
    logic [14:0]   glyph_bits;
    logic          seen, shown, lit, vis0, vis1, visible;

    assign vis0 = !((blink0 != '0) && blink0[BLINK_BIT]);
    assign vis1 = !((blink1 != '0) && blink1[BLINK_BIT]);

    always_comb begin
        bcd_sel = s1_p ? bcd1 : bcd0;
        digit   = 4'd0;
        seen    = 1'b0;
        shown   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_sel[4*(DIGITS-1-i) +: 4] != 4'd0) seen = 1'b1;
            if (s1_dig == 3'(i)) begin
                digit = bcd_sel[4*(DIGITS-1-i) +: 4];
                shown = seen || (i == DIGITS - 1);
            end
        end
        glyph_bits = glyph(digit);
        bit_idx    = 4'd14 - (4'(s1_row) * 4'd3 + 4'(s1_col));
        lit        = glyph_bits[bit_idx];
        visible    = s1_p ? vis1 : vis0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color      <= '0;
            in_overlay <= 1'b0;
        end else if (s1_hit && s1_en && shown && lit && visible) begin
            color      <= s1_p ? FG1 : FG0;
            in_overlay <= 1'b1;
        end else begin
            color      <= s1_bg;
            in_overlay <= 1'b0;
        end
    end
endmodule

// File: tb/tb_score_overlay_px.sv
// Bench for score_overlay_px: random pixel traffic scored against a digit/blink model,
// plus directed checks of busy timing, async reset, priority, saturation and blanking.
module tb_score_overlay_px;
    localparam int          SCORE_Y      = 8;
    localparam int          P0_X         = 16;
    localparam int          P1_X         = 560;
    localparam int          DIGITS       = 3;
    localparam int          BLINK_FRAMES = 32;
    localparam logic [23:0] FG0          = 24'hFFFFFF;
    localparam logic [23:0] FG1          = 24'hFF4040;

    localparam logic [2:0] FONT [10][5] = '{
        '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
        '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
        '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
        '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
        '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
        '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
        '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
        '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] your_score, their_score, game_state, pixel_x, pixel_y;
    logic        frame_start;
    logic [23:0] bg_color;
    logic [23:0] color;
    logic        in_overlay, busy;

    score_overlay_px dut (
        .clk(clk), .rst(rst), .your_score(your_score), .their_score(their_score),
        .game_state(game_state), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .bg_color(bg_color), .color(color),
        .in_overlay(in_overlay), .busy(busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [24:0] exp_q[$];
    int          xq[$];
    int          yq[$];
    logic        drv_valid = 1'b0;
    int          disp[2];
    int          blink[2];
    int          cyc = 0;
    int          busy_hi = 0;
    int          last_rise = 0;
    int          last_fall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: what the screen should show at (x,y) given displayed scores and blink counters.
    function automatic logic [24:0] model_px(input int x, input int y, input logic [23:0] bg,
                                             input logic [15:0] gs);
        logic [24:0] r;
        r = {1'b0, bg};
        if (gs[1:0] == 2'b00) return r;
        for (int p = 0; p < 2; p++) begin
            int px, dx, d, off, v, pw, dg, row, col;
            bit shown, vis;
            px = (p == 0) ? P0_X : P1_X;
            if (y >= SCORE_Y && y < SCORE_Y + 20 && x >= px) begin
                dx  = x - px;
                d   = dx / 16;
                off = dx % 16;
                if (d < DIGITS && off < 12) begin
                    v     = (disp[p] >= 10 ** DIGITS) ? 10 ** DIGITS - 1 : disp[p];
                    pw    = 10 ** (DIGITS - 1 - d);
                    dg    = (v / pw) % 10;
                    shown = (d == DIGITS - 1) || (v >= pw);
                    row   = (y - SCORE_Y) / 4;
                    col   = off / 4;
                    vis   = !(blink[p] != 0 && ((blink[p] / 4) % 2 == 1));
                    if (shown && vis && FONT[dg][row][2-col] == 1'b1)
                        r = {1'b1, (p == 0) ? FG0 : FG1};
                end
            end
        end
        return r;
    endfunction

    task automatic drive_px(input int x, input int y, input logic [23:0] bg, input logic [15:0] gs);
        @(posedge clk); #1;
        pixel_x    = 16'(x);
        pixel_y    = 16'(y);
        bg_color   = bg;
        game_state = gs;
        drv_valid  = 1'b1;
        exp_q.push_back(model_px(x, y, bg, gs));
        xq.push_back(x);
        yq.push_back(y);
    endtask

    task automatic end_burst();
        @(posedge clk); #1;
        drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_gs_on();
        logic [15:0] g;
        g      = 16'($urandom);
        g[1:0] = 2'($urandom_range(1, 3));
        return g;
    endfunction

    task automatic scan_row(input int p, input int y);
        int px;
        px = (p == 0) ? P0_X : P1_X;
        for (int x = px - 2; x <= px + 50; x++)
            drive_px(x, y, 24'($urandom), rand_gs_on());
    endtask

    task automatic scan_field(input int p);
        for (int y = SCORE_Y - 1; y <= SCORE_Y + 20; y++) scan_row(p, y);
        end_burst();
    endtask

    task automatic frame_pulse();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int p = 0; p < 2; p++) if (blink[p] > 0) blink[p]--;
    endtask

    task automatic wait_busy(input logic val, input int limit, input string name);
        int n;
        n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== val) begin
            errors++;
            $display("FAIL %s: busy=%b after %0d cycles, required %b", name, busy, n, val);
        end
        #1;
    endtask

    task automatic monitor_loop();
        logic        d1, d2;
        logic [24:0] e;
        int          ex, ey;
        d1 = 1'b0;
        d2 = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                d1 = 1'b0;
                d2 = 1'b0;
            end else begin
                if (d2) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL queue_underflow: output with no expected entry");
                    end else begin
                        e  = exp_q.pop_front();
                        ex = xq.pop_front();
                        ey = yq.pop_front();
                        if ({in_overlay, color} !== e) begin
                            errors++;
                            $display("FAIL pixel x=%0d y=%0d: got overlay=%b color=%h, required overlay=%b color=%h",
                                     ex, ey, in_overlay, color, e[24], e[23:0]);
                        end
                    end
                end
                d2 = d1;
                d1 = drv_valid;
            end
        end
    endtask

    task automatic busy_loop();
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_hi++;
            if (busy === 1'b1 && !prev) last_rise = cyc;
            if (busy !== 1'b1 && prev) last_fall = cyc;
            prev = (busy === 1'b1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi0, rise0, ny, nt, nf, p, x, y;
        rst         = 1'b0;
        your_score  = '0;
        their_score = '0;
        game_state  = 16'h0001;
        pixel_x     = '0;
        pixel_y     = '0;
        bg_color    = '0;
        frame_start = 1'b0;
        disp        = '{0, 0};
        blink       = '{0, 0};
        fork
            monitor_loop();
            busy_loop();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_color", 32'(color), 32'h0);
        check("reset_in_overlay", 32'(in_overlay), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 32'(busy), 32'h0);
        scan_field(0);
        scan_field(1);

        // T1: async reset in the middle of a conversion
        for (int i = 0; i < 3; i++) drive_px(300, 100, 24'hA5A5A5, 16'h0001);
        end_burst();
        your_score = 16'd123;
        wait_busy(1'b1, 10, "t1_busy_rise");
        repeat (4) @(negedge clk);
        check("t1_busy_mid_conv", 32'(busy), 32'h1);
        check("t1_color_before_reset", 32'(color), 32'hA5A5A5);
        rst = 1'b0;
        #1;
        check("t1_async_color", 32'(color), 32'h0);
        check("t1_async_busy", 32'(busy), 32'h0);
        check("t1_async_overlay", 32'(in_overlay), 32'h0);
        your_score = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("t1_no_conversion", 32'(busy), 32'h0);
        scan_row(0, SCORE_Y);
        scan_row(0, SCORE_Y + 16);
        end_burst();

        // T2: 0 -> 123, busy for exactly 16 cycles
        hi0 = busy_hi;
        your_score = 16'd123;
        wait_busy(1'b1, 10, "t2_busy_rise");
        rise0 = last_rise;
        wait_busy(1'b0, 40, "t2_busy_fall");
        check("t2_busy_cycles", 32'(busy_hi - hi0), 32'd16);
        check("t2_busy_span", 32'(last_fall - rise0), 32'd16);
        repeat (3) @(posedge clk);
        #1;
        disp[0]  = 123;
        blink[0] = BLINK_FRAMES;
        scan_field(0);
        scan_field(1);

        // T4: blink over 34 frames
        for (int f = 0; f < 34; f++) begin
            frame_pulse();
            scan_row(0, SCORE_Y);
            end_burst();
        end

        // T3: simultaneous change, player 0 first, player 1 saturates
        hi0 = busy_hi;
        @(posedge clk); #1;
        your_score  = 16'd7;
        their_score = 16'd1500;
        wait_busy(1'b1, 10, "t3_busy_rise");
        rise0 = last_rise;
        repeat (16) @(posedge clk);
        disp[0]  = 7;
        blink[0] = BLINK_FRAMES;
        drive_px(P0_X + 32, SCORE_Y + 4, 24'h010203, 16'h0001);
        drive_px(P0_X + 32, SCORE_Y, 24'h010203, 16'h0001);
        drive_px(P1_X, SCORE_Y, 24'h040506, 16'h0001);
        drive_px(P1_X + 32, SCORE_Y + 12, 24'h040506, 16'h0001);
        end_burst();
        wait_busy(1'b0, 40, "t3_busy_fall");
        check("t3_busy_cycles", 32'(busy_hi - hi0), 32'd32);
        check("t3_busy_span", 32'(last_fall - rise0), 32'd34);
        repeat (3) @(posedge clk);
        #1;
        disp[1]  = 1500;
        blink[1] = BLINK_FRAMES;
        scan_field(0);
        scan_field(1);

        // T6: leading-zero blanking on player 1
        their_score = 16'd5;
        wait_busy(1'b1, 10, "t6_busy_rise");
        wait_busy(1'b0, 40, "t6_busy_fall");
        repeat (3) @(posedge clk);
        #1;
        disp[1]  = 5;
        blink[1] = BLINK_FRAMES;
        scan_field(1);

        // T5: overlay hidden -> pure 2-cycle pass-through
        for (int i = 0; i < 300; i++) begin
            logic [15:0] g;
            g      = 16'($urandom);
            g[1:0] = 2'b00;
            if (i % 2 == 0) begin
                p = $urandom_range(0, 1);
                x = ((p == 0) ? P0_X : P1_X) + $urandom_range(0, 50);
                y = $urandom_range(SCORE_Y, SCORE_Y + 19);
            end else begin
                x = $urandom_range(0, 639);
                y = $urandom_range(0, 479);
            end
            drive_px(x, y, 24'($urandom), g);
        end
        end_burst();

        // Random score / frame / pixel rounds
        for (int r = 0; r < 5; r++) begin
            ny = $urandom_range(0, 1200);
            nt = $urandom_range(0, 1200);
            @(posedge clk); #1;
            your_score  = 16'(ny);
            their_score = 16'(nt);
            repeat (45) @(posedge clk);
            #1;
            check("rnd_idle", 32'(busy), 32'h0);
            if (ny != disp[0]) begin disp[0] = ny; blink[0] = BLINK_FRAMES; end
            if (nt != disp[1]) begin disp[1] = nt; blink[1] = BLINK_FRAMES; end
            nf = $urandom_range(0, 14);
            for (int f = 0; f < nf; f++) frame_pulse();
            for (int i = 0; i < 250; i++) begin
                if (i % 4 != 0) begin
                    p = $urandom_range(0, 1);
                    x = ((p == 0) ? P0_X : P1_X) + $urandom_range(0, 52) - 2;
                    y = $urandom_range(SCORE_Y - 2, SCORE_Y + 21);
                end else begin
                    x = $urandom_range(0, 639);
                    y = $urandom_range(0, 479);
                end
                drive_px(x, y, 24'($urandom), 16'($urandom));
            end
            end_burst();
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
